eth_fcs_checker: RTL

Consumes the received byte stream from the RMII receive stage: preamble/SFD already stripped, one byte per beat, no backpressure. Checks the Ethernet CRC-32 FCS and frame length, strips the 4 FCS bytes, and forwards the payload (destination MAC through the end of data) downstream. A bad FCS, a bad length or an upstream error is flagged with tuser on the tlast beat.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_crc32_byte.sv | 32 +++
 rtl/eth_fcs_checker.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet constants for the receive FCS checker and the transmit-side
// FCS generator.
//   CRC32_POLY_REFL : reflected CRC-32 polynomial (LSB-first processing)
//   CRC32_INIT      : CRC register value at the start of every frame
//   CRC32_RESIDUE   : register value after a frame whose FCS is correct
//   ETH_MIN_FRAME   : minimum legal frame length in bytes, FCS included
//   ETH_MAX_FRAME   : maximum legal untagged frame length, FCS included
// ---------------------------------------------------------------------------
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;

    // Number of trailing FCS bytes held back by the delay line.
    localparam int FCS_BYTES = 4;

    // Saturation value of the 16-bit frame length counter.
    localparam logic [15:0] LEN_SAT = 16'hFFFF;

endpackage

// File: rtl/eth_crc32_byte.sv
// ---------------------------------------------------------------------------
// eth_crc32_byte
// Purely combinational one-byte step of the reflected Ethernet CRC-32.
// The byte is consumed LSB first, so no bit reversal is needed anywhere.
// Ports:
//   crc_in  [31:0] : current CRC register value
//   data    [7:0]  : byte to fold into the CRC
//   crc_out [31:0] : CRC register value after the byte
// ---------------------------------------------------------------------------
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/eth_fcs_checker.sv
// ---------------------------------------------------------------------------
// eth_fcs_checker
// Receive-side FCS and length checker. Takes the de-framed RMII byte stream
// (preamble/SFD removed), checks CRC-32 and frame length, strips the four FCS
// bytes through a 4-byte delay line and forwards the remaining payload.
// Errors are reported with maxis_tuser on the maxis_tlast beat.
//
// Stream semantics (both sides): there is no tready. A beat is transferred on
// every rising clock edge where tvalid=1; tdata/tuser/tlast are only
// meaningful while tvalid=1. Output beats appear one cycle after the input
// beat that produced them; idle input cycles appear as idle output cycles.
//
// Ports:
//   clock, aresetn       : clock, synchronous active-low reset
//   saxis_tdata  [7:0]   : received byte
//   saxis_tvalid         : received byte valid
//   saxis_tuser          : upstream error, sticky for the rest of the frame
//   saxis_tlast          : final byte of the frame (last FCS byte)
//   maxis_tdata  [7:0]   : payload byte
//   maxis_tvalid         : payload byte valid
//   maxis_tuser          : frame error, only meaningful with maxis_tlast
//   maxis_tlast          : last payload byte of the frame
//   fcs_ok               : pulse, frame completed without error
//   fcs_err              : pulse, frame completed with error
//   runt_drop            : pulse, frame of 4 bytes or fewer discarded
// ---------------------------------------------------------------------------
module eth_fcs_checker
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_FRAME,
    parameter int MAX_LEN = ETH_MAX_FRAME
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    input  logic       saxis_tuser,
    input  logic       saxis_tlast,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    output logic       maxis_tuser,
    output logic       maxis_tlast,
    output logic       fcs_ok,
    output logic       fcs_err,
    output logic       runt_drop
);

    localparam logic [31:0] LP_MIN_LEN = 32'(MIN_LEN);
    localparam logic [31:0] LP_MAX_LEN = 32'(MAX_LEN);
    localparam logic [2:0]  LP_FULL    = 3'(FCS_BYTES);

    // Frame state
    logic [31:0] r_crc;
    logic [31:0] r_dly;      // oldest byte in [31:24], newest in [7:0]
    logic [2:0]  r_fill;
    logic [15:0] r_len;
    logic        r_uerr;

    // Output registers
    logic [7:0]  r_m_tdata;
    logic        r_m_tvalid;
    logic        r_m_tuser;
    logic        r_m_tlast;
    logic        r_fcs_ok;
    logic        r_fcs_err;
    logic        r_runt_drop;

    // Next-state view including the beat currently presented
    logic [31:0] w_crc_next;
    logic [15:0] w_len_next;
    logic [31:0] w_len32;
    logic        w_uerr_next;
    logic        w_emit;
    logic        w_runt;
    logic        w_crc_bad;
    logic        w_too_short;
    logic        w_too_long;
    logic        w_frame_bad;

    eth_crc32_byte u_crc (
        .crc_in  (r_crc),
        .data    (saxis_tdata),
        .crc_out (w_crc_next)
    );

    always_comb begin
        w_len_next  = (r_len == LEN_SAT) ? LEN_SAT : (r_len + 16'd1);
        w_len32     = {16'd0, w_len_next};
        w_uerr_next = r_uerr | saxis_tuser;
        w_emit      = (r_fill == LP_FULL);
        // A frame with at most FCS_BYTES bytes carries no payload at all.
        w_runt      = (w_len_next <= 16'(FCS_BYTES));
        w_crc_bad   = (w_crc_next != CRC32_RESIDUE);
        w_too_short = (LP_MIN_LEN != 32'd0) && (w_len32 < LP_MIN_LEN);
        w_too_long  = (w_len32 > LP_MAX_LEN);
        w_frame_bad = w_crc_bad | w_too_short | w_too_long | w_uerr_next;
    end

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            r_crc       <= CRC32_INIT;
            r_dly       <= 32'd0;
            r_fill      <= 3'd0;
            r_len       <= 16'd0;
            r_uerr      <= 1'b0;
            r_m_tdata   <= 8'd0;
            r_m_tvalid  <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_fcs_ok    <= 1'b0;
            r_fcs_err   <= 1'b0;
            r_runt_drop <= 1'b0;
        end else begin
            r_m_tvalid  <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_fcs_ok    <= 1'b0;
            r_fcs_err   <= 1'b0;
            r_runt_drop <= 1'b0;

            if (saxis_tvalid) begin
                r_dly <= {r_dly[23:0], saxis_tdata};

                if (w_emit) begin
                    r_m_tvalid <= 1'b1;
                    r_m_tdata  <= r_dly[31:24];
                end

                if (saxis_tlast) begin
                    // A non-runt frame has seen at least four earlier beats,
                    // so the delay line is full and w_emit is set here.
                    if (!w_runt) begin
                        r_m_tlast <= 1'b1;
                        r_m_tuser <= w_frame_bad;
                        r_fcs_ok  <= ~w_frame_bad;
                        r_fcs_err <= w_frame_bad;
                    end else begin
                        r_runt_drop <= 1'b1;
                    end
                    r_crc  <= CRC32_INIT;
                    r_fill <= 3'd0;
                    r_len  <= 16'd0;
                    r_uerr <= 1'b0;
                end else begin
                    r_crc  <= w_crc_next;
                    r_len  <= w_len_next;
                    r_uerr <= w_uerr_next;
                    if (!w_emit) begin
                        r_fill <= r_fill + 3'd1;
                    end
                end
            end
        end
    end

    assign maxis_tdata  = r_m_tdata;
    assign maxis_tvalid = r_m_tvalid;
    assign maxis_tuser  = r_m_tuser;
    assign maxis_tlast  = r_m_tlast;
    assign fcs_ok       = r_fcs_ok;
    assign fcs_err      = r_fcs_err;
    assign runt_drop    = r_runt_drop;

endmodule
